// File: rtl/tx_frame_arbiter_pkg.sv
// ============================================================================
// Module   : tx_frame_arbiter_pkg
// Brief    : Shared encodings for the transmitter frame arbiter and its users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_frame_arbiter_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT_EN = 3'd2;
    localparam logic [2:0] S_BUSY    = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    localparam logic [7:0] CMD_RD0 = 8'h80;
    localparam logic [7:0] CMD_RD1 = 8'h81;
    localparam logic [7:0] CMD_WR0 = 8'h00;
    localparam logic [7:0] CMD_WR1 = 8'h01;

    // Index width that stays at least one bit wide for tiny counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_frame_arbiter_rr_pick.sv
// ============================================================================
// Module   : txarb_rr_pick
// Brief    : Combinational winner picker; round-robin from ptr+1, or fixed
//            lowest-index priority when TXARB_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module txarb_rr_pick
    import tx_frame_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

`ifdef TXARB_FIXED_PRIO_EN
    // Starting the scan after the last index makes index 0 the top priority.
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;
    assign w_start      = IDX_W'(N_REQ - 1);
`else
    assign w_start = ptr;
`endif

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        winner  = '0;
        win_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(w_start) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found         = 1'b1;
                winner[w_cand]  = 1'b1;
                win_idx         = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_frame_arbiter.sv
// ============================================================================
// Module   : tx_frame_arbiter
// Brief    : Shares one reply transmitter among N_REQ requesters; grants one,
//            latches its frame header, pulses start and routes data until the
//            frame ends plus a fixed gap. Option macro: TXARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_frame_arbiter
    import tx_frame_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GAP_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [8*N_REQ-1:0]    req_com,
    input  logic [8*N_REQ-1:0]    req_lbl,
    input  logic [16*N_REQ-1:0]   req_adr,
    input  logic [8*N_REQ-1:0]    req_dat,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [15:0]           rd_adr,
    output logic                  tx_st,
    output logic [7:0]            tx_com,
    output logic [7:0]            tx_lbl,
    output logic [15:0]           tx_adr,
    output logic [7:0]            tx_dat,
    input  logic                  tx_en,
    input  logic [15:0]           tx_rd_adr,
    output logic                  busy
);

    localparam int               c_IDX_W    = idx_width(N_REQ);
    localparam int               c_CNT_W    = idx_width(GAP_CYC);
    localparam logic [c_IDX_W-1:0] c_PTR_RST  = c_IDX_W'(N_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYC - 1);

    logic [2:0]          r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_win;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic                r_tx_st;
    logic [7:0]          r_tx_com;
    logic [7:0]          r_tx_lbl;
    logic [15:0]         r_tx_adr;
    logic [c_CNT_W-1:0]  r_gap_cnt;

    logic [N_REQ-1:0]    w_pick_onehot;
    logic [c_IDX_W-1:0]  w_pick_idx;

    txarb_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (r_rr_ptr),
        .winner  (w_pick_onehot),
        .win_idx (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= c_PTR_RST;
            r_win     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_tx_st   <= 1'b0;
            r_tx_com  <= '0;
            r_tx_lbl  <= '0;
            r_tx_adr  <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_tx_st <= 1'b0;
            r_done  <= '0;
            case (r_state)
                // A transmitter still running (e.g. after a reset) blocks new grants.
                S_IDLE: begin
                    if (|req && !tx_en) begin
                        r_gnt    <= w_pick_onehot;
                        r_win    <= w_pick_idx;
                        r_rr_ptr <= w_pick_idx;
                        r_tx_com <= req_com[8*w_pick_idx +: 8];
                        r_tx_lbl <= req_lbl[8*w_pick_idx +: 8];
                        r_tx_adr <= req_adr[16*w_pick_idx +: 16];
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_tx_st <= 1'b1;
                    r_state <= S_WAIT_EN;
                end
                S_WAIT_EN: begin
                    if (tx_en) begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!tx_en) begin
                        r_done    <= r_gnt;
                        r_gnt     <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign tx_st  = r_tx_st;
    assign tx_com = r_tx_com;
    assign tx_lbl = r_tx_lbl;
    assign tx_adr = r_tx_adr;
    assign rd_adr = tx_rd_adr;
    assign tx_dat = (|r_gnt) ? req_dat[8*r_win +: 8] : 8'h00;
    assign busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire
